// File: rtl/aes_chk_pkg.sv
// Shared types and helpers for the AES vector checker: FSM encodings, load selectors
// and the completed_round progression rule.
package aes_chk_pkg;

  typedef enum logic [2:0] {
    L_IDLE  = 3'd0,
    L_FETCH = 3'd1,
    L_ISSUE = 3'd2,
    L_WAIT  = 3'd3,
    L_CHECK = 3'd4,
    L_SKIP  = 3'd5,
    L_DONE  = 3'd6
  } lane_state_t;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_RUN    = 2'd1,
    T_REPORT = 2'd2
  } top_state_t;

  localparam logic [1:0] LD_PLAIN = 2'd0;
  localparam logic [1:0] LD_KEY   = 2'd1;
  localparam logic [1:0] LD_EXP   = 2'd2;

  // Legal when cur is one-hot and is bit0 (no history) or exactly last shifted left by one.
  function automatic logic onehot_next(input logic [31:0] last, input logic [31:0] cur);
    logic        is_onehot;
    logic [31:0] want;
    is_onehot = (cur != 32'd0) && ((cur & (cur - 32'd1)) == 32'd0);
    if (last == 32'd0) begin
      want = 32'd1;
    end else begin
      want = last << 1;
    end
    return is_onehot && (cur == want);
  endfunction

endpackage

// File: rtl/aes_vector_checker_lane.sv
// One lane of the checker: walks its share of the vector set through a single AES core,
// timing out stalled vectors and watching the completed_round progress bus.
module aes_chk_lane
  import aes_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 1000,
  parameter int NUM_LANES   = 1,
  parameter int LANE_ID     = 0,
  parameter int DATA_W      = 128,
  parameter int ROUNDS      = 10,
  parameter int TIMEOUT     = 64,
  parameter int VW          = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_go,
  input  logic              i_grant,
  input  logic              i_done,
  input  logic [DATA_W-1:0] i_cipher_text,
  input  logic [DATA_W-1:0] i_expected,
  input  logic [ROUNDS-1:0] i_completed_round,
  output logic              o_req,
  output logic [VW-1:0]     o_idx,
  output logic              o_start,
  output logic              o_lane_done,
  output logic              o_mismatch,
  output logic              o_timeout,
  output logic              o_round_err
);

  localparam int IW = VW + 4;
  localparam int CW = $clog2(TIMEOUT + 1);

  lane_state_t       r_state;
  lane_state_t       w_next;
  logic [VW-1:0]     r_idx;
  logic [DATA_W-1:0] r_ct;
  logic [CW-1:0]     r_cnt;
  logic [ROUNDS-1:0] r_last_round;
  logic              r_start;
  logic [IW-1:0]     w_idx_next;
  logic              w_more;
  logic              w_timeout;
  logic              w_round_bad;
  logic [31:0]       w_round32;
  logic [31:0]       w_last32;

  assign w_idx_next = {4'b0000, r_idx} + IW'(NUM_LANES);
  assign w_more     = (w_idx_next < IW'(NUM_VECTORS));
  assign w_timeout  = (r_state == L_WAIT) && !i_done && (r_cnt >= CW'(TIMEOUT - 1));
  assign w_round32  = 32'(i_completed_round);
  assign w_last32   = 32'(r_last_round);
  // A held value is not progress, so only a change of the nonzero bus is judged.
  assign w_round_bad = (r_state == L_WAIT) && (i_completed_round != {ROUNDS{1'b0}}) &&
                       (i_completed_round != r_last_round) && !onehot_next(w_last32, w_round32);

  always_comb begin
    w_next = r_state;
    case (r_state)
      L_IDLE, L_DONE: begin
        if (i_go) begin
          w_next = (LANE_ID < NUM_VECTORS) ? L_FETCH : L_DONE;
        end else begin
          w_next = r_state;
        end
      end
      L_FETCH: w_next = i_grant ? L_ISSUE : L_FETCH;
      L_ISSUE: w_next = L_WAIT;
      L_WAIT: begin
        if (i_done) begin
          w_next = L_CHECK;
        end else if (w_timeout) begin
          w_next = L_SKIP;
        end else begin
          w_next = L_WAIT;
        end
      end
      L_CHECK, L_SKIP: w_next = w_more ? L_FETCH : L_DONE;
      default: w_next = L_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= L_IDLE;
      r_idx        <= {VW{1'b0}};
      r_ct         <= {DATA_W{1'b0}};
      r_cnt        <= {CW{1'b0}};
      r_last_round <= {ROUNDS{1'b0}};
      r_start      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= (w_next == L_ISSUE) || (w_next == L_WAIT);
      if (i_go && ((r_state == L_IDLE) || (r_state == L_DONE))) begin
        r_idx <= VW'(LANE_ID);
      end
      if (((r_state == L_CHECK) || (r_state == L_SKIP)) && w_more) begin
        r_idx <= w_idx_next[VW-1:0];
      end
      if (r_state == L_ISSUE) begin
        r_cnt        <= CW'(1);
        r_last_round <= {ROUNDS{1'b0}};
      end
      if (r_state == L_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
        if (i_completed_round != {ROUNDS{1'b0}}) begin
          r_last_round <= i_completed_round;
        end
        if (i_done) begin
          r_ct <= i_cipher_text;
        end
      end
    end
  end

  assign o_req       = (r_state == L_FETCH);
  assign o_idx       = r_idx;
  assign o_start     = r_start;
  assign o_lane_done = (r_state == L_DONE);
  assign o_mismatch  = ((r_state == L_CHECK) && (r_ct != i_expected)) || (r_state == L_SKIP);
  assign o_timeout   = w_timeout;
  assign o_round_err = w_round_bad;

endmodule

// File: rtl/aes_vector_checker.sv
// Self-checking AES vector engine: vector RAMs, round-robin fetch arbiter across lanes,
// error accumulation and the run/report sequencing.
module aes_vector_checker
  import aes_chk_pkg::*;
#(
  parameter  int NUM_VECTORS = 1000,
  parameter  int NUM_LANES   = 1,
  parameter  int DATA_W      = 128,
  parameter  int ROUNDS      = 10,
  parameter  int TIMEOUT     = 64,
  localparam int VW          = $clog2(NUM_VECTORS)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_ld_en,
  input  logic [1:0]                  i_ld_sel,
  input  logic [VW-1:0]               i_ld_addr,
  input  logic [DATA_W-1:0]           i_ld_data,
  input  logic                        i_run,
  output logic [NUM_LANES-1:0]        o_dut_start,
  output logic [NUM_LANES*DATA_W-1:0] o_dut_plain_text,
  output logic [NUM_LANES*DATA_W-1:0] o_dut_cipher_key,
  input  logic [NUM_LANES-1:0]        i_dut_done,
  input  logic [NUM_LANES*DATA_W-1:0] i_dut_cipher_text,
  input  logic [NUM_LANES*ROUNDS-1:0] i_dut_completed_round,
  output logic                        o_busy,
  output logic                        o_finished,
  output logic                        o_pass,
  output logic [VW:0]                 o_error_count,
  output logic [VW-1:0]               o_first_fail_idx,
  output logic                        o_timeout_err,
  output logic                        o_round_err
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int EW = VW + 1;

  logic [DATA_W-1:0] r_ram_plain [NUM_VECTORS];
  logic [DATA_W-1:0] r_ram_key   [NUM_VECTORS];
  logic [DATA_W-1:0] r_ram_exp   [NUM_VECTORS];
  logic [DATA_W-1:0] r_lane_plain [NUM_LANES];
  logic [DATA_W-1:0] r_lane_key   [NUM_LANES];
  logic [DATA_W-1:0] r_lane_exp   [NUM_LANES];

  logic [NUM_LANES-1:0] w_req;
  logic [NUM_LANES-1:0] w_lane_done;
  logic [NUM_LANES-1:0] w_mm;
  logic [NUM_LANES-1:0] w_to;
  logic [NUM_LANES-1:0] w_rerr;
  logic [NUM_LANES-1:0] w_grant;
  logic [VW-1:0]        w_idx [NUM_LANES];

  top_state_t    r_state;
  top_state_t    w_next;
  logic          w_go;
  logic [LW-1:0] r_rr;
  logic          w_gnt_any;
  logic [LW-1:0] w_gnt_lane;
  logic [LW:0]   w_j;
  logic [VW-1:0] w_rd_addr;
  logic [3:0]    w_pop;
  logic [EW:0]   w_err_sum;
  logic [EW-1:0] w_err_next;
  logic          w_ff_any;
  logic [VW-1:0] w_ff_min;

  logic          r_busy;
  logic          r_finished;
  logic          r_pass;
  logic [EW-1:0] r_err;
  logic [VW-1:0] r_ffi;
  logic          r_to;
  logic          r_rerr;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    aes_chk_lane #(
      .NUM_VECTORS(NUM_VECTORS), .NUM_LANES(NUM_LANES), .LANE_ID(l), .DATA_W(DATA_W),
      .ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT), .VW(VW)
    ) u_lane (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .i_go              (w_go),
      .i_grant           (w_grant[l]),
      .i_done            (i_dut_done[l]),
      .i_cipher_text     (i_dut_cipher_text[l*DATA_W +: DATA_W]),
      .i_expected        (r_lane_exp[l]),
      .i_completed_round (i_dut_completed_round[l*ROUNDS +: ROUNDS]),
      .o_req             (w_req[l]),
      .o_idx             (w_idx[l]),
      .o_start           (o_dut_start[l]),
      .o_lane_done       (w_lane_done[l]),
      .o_mismatch        (w_mm[l]),
      .o_timeout         (w_to[l]),
      .o_round_err       (w_rerr[l])
    );
    assign o_dut_plain_text[l*DATA_W +: DATA_W] = r_lane_plain[l];
    assign o_dut_cipher_key[l*DATA_W +: DATA_W] = r_lane_key[l];
  end

  assign w_go = (r_state == T_IDLE) && i_run;

  // Search starts at the lane after the last winner so no FETCH lane starves.
  always_comb begin
    w_gnt_any  = 1'b0;
    w_gnt_lane = {LW{1'b0}};
    w_j        = {(LW+1){1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      w_j = {1'b0, r_rr} + (LW+1)'(i);
      if (w_j >= (LW+1)'(NUM_LANES)) begin
        w_j = w_j - (LW+1)'(NUM_LANES);
      end else begin
        w_j = w_j;
      end
      if (!w_gnt_any && w_req[w_j[LW-1:0]]) begin
        w_gnt_any  = 1'b1;
        w_gnt_lane = w_j[LW-1:0];
      end else begin
        w_gnt_any  = w_gnt_any;
      end
    end
    w_grant   = w_gnt_any ? (NUM_LANES'(1'b1) << w_gnt_lane) : {NUM_LANES{1'b0}};
    w_rd_addr = w_idx[w_gnt_lane];
  end

  always_comb begin
    w_pop    = 4'd0;
    w_ff_any = 1'b0;
    w_ff_min = {VW{1'b1}};
    for (int l = 0; l < NUM_LANES; l++) begin
      w_pop = w_pop + 4'(w_mm[l]);
      if (w_mm[l] && (!w_ff_any || (w_idx[l] < w_ff_min))) begin
        w_ff_any = 1'b1;
        w_ff_min = w_idx[l];
      end else begin
        w_ff_any = w_ff_any;
      end
    end
    w_err_sum  = {1'b0, r_err} + (EW+1)'(w_pop);
    w_err_next = w_err_sum[EW] ? {EW{1'b1}} : w_err_sum[EW-1:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      T_IDLE:   w_next = i_run ? T_RUN : T_IDLE;
      T_RUN:    w_next = (&w_lane_done) ? T_REPORT : T_RUN;
      T_REPORT: w_next = T_IDLE;
      default:  w_next = T_IDLE;
    endcase
  end

  // Vector storage survives reset so a re-run after an abort needs no reload.
  always_ff @(posedge i_clk) begin
    if (i_ld_en && (r_state == T_IDLE) && ({1'b0, i_ld_addr} < (VW+1)'(NUM_VECTORS))) begin
      case (i_ld_sel)
        LD_PLAIN: r_ram_plain[i_ld_addr] <= i_ld_data;
        LD_KEY:   r_ram_key[i_ld_addr]   <= i_ld_data;
        LD_EXP:   r_ram_exp[i_ld_addr]   <= i_ld_data;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        r_lane_plain[l] <= {DATA_W{1'b0}};
        r_lane_key[l]   <= {DATA_W{1'b0}};
        r_lane_exp[l]   <= {DATA_W{1'b0}};
      end
    end else if (w_gnt_any) begin
      r_lane_plain[w_gnt_lane] <= r_ram_plain[w_rd_addr];
      r_lane_key[w_gnt_lane]   <= r_ram_key[w_rd_addr];
      r_lane_exp[w_gnt_lane]   <= r_ram_exp[w_rd_addr];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= T_IDLE;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= {EW{1'b0}};
      r_ffi      <= {VW{1'b1}};
      r_to       <= 1'b0;
      r_rerr     <= 1'b0;
      r_rr       <= {LW{1'b0}};
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != T_IDLE);
      if (w_gnt_any) begin
        r_rr <= (w_gnt_lane == LW'(NUM_LANES - 1)) ? {LW{1'b0}} : (w_gnt_lane + LW'(1));
      end
      if (w_go) begin
        r_finished <= 1'b0;
        r_pass     <= 1'b0;
        r_err      <= {EW{1'b0}};
        r_ffi      <= {VW{1'b1}};
        r_to       <= 1'b0;
        r_rerr     <= 1'b0;
      end else begin
        if (r_state == T_RUN) begin
          r_err <= w_err_next;
          if (w_ff_any && (r_ffi == {VW{1'b1}})) begin
            r_ffi <= w_ff_min;
          end
          if (|w_to) begin
            r_to <= 1'b1;
          end
          if (|w_rerr) begin
            r_rerr <= 1'b1;
          end
        end
        // Every lane is parked in DONE here, so the accumulators are already final.
        if (w_next == T_REPORT) begin
          r_finished <= 1'b1;
          r_pass     <= (r_err == {EW{1'b0}}) && !r_to && !r_rerr;
        end
      end
    end
  end

  assign o_busy           = r_busy;
  assign o_finished       = r_finished;
  assign o_pass           = r_pass;
  assign o_error_count    = r_err;
  assign o_first_fail_idx = r_ffi;
  assign o_timeout_err    = r_to;
  assign o_round_err      = r_rerr;

endmodule

// File: tb/tb_aes_vector_checker.sv
// Directed bench: four-lane checker over ten vectors (vector 0 is FIPS-197 C.1) with a
// behavioural AES stand-in that can corrupt, hang or mis-sequence rounds per vector.
module tb_aes_vector_checker;

  localparam int NV  = 10;
  localparam int NL  = 4;
  localparam int DW  = 128;
  localparam int RN  = 10;
  localparam int TO  = 20;
  localparam int VW  = 4;
  localparam int LAT = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_en;
  logic [1:0]        ld_sel;
  logic [VW-1:0]     ld_addr;
  logic [DW-1:0]     ld_data;
  logic              run;
  logic [NL-1:0]     dut_start;
  logic [NL*DW-1:0]  dut_plain_text;
  logic [NL*DW-1:0]  dut_cipher_key;
  logic [NL-1:0]     dut_done = '0;
  logic [NL*DW-1:0]  dut_cipher_text = '0;
  logic [NL*RN-1:0]  dut_completed_round = '0;
  logic              busy;
  logic              finished;
  logic              pass;
  logic [VW:0]       error_count;
  logic [VW-1:0]     first_fail_idx;
  logic              timeout_err;
  logic              round_err;

  logic [DW-1:0] pt_tab [NV];
  logic [DW-1:0] key_tab [NV];
  logic [DW-1:0] ct_tab [NV];
  logic [NV-1:0] corrupt_mask = '0;
  logic [NV-1:0] hang_mask = '0;
  logic          round_bad = 1'b0;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  m_cnt [NL];
  int  m_vec [NL];
  logic m_act [NL];

  always #5 clk = ~clk;

  aes_vector_checker #(
    .NUM_VECTORS(NV), .NUM_LANES(NL), .DATA_W(DW), .ROUNDS(RN), .TIMEOUT(TO)
  ) u_dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_ld_en               (ld_en),
    .i_ld_sel              (ld_sel),
    .i_ld_addr             (ld_addr),
    .i_ld_data             (ld_data),
    .i_run                 (run),
    .o_dut_start           (dut_start),
    .o_dut_plain_text      (dut_plain_text),
    .o_dut_cipher_key      (dut_cipher_key),
    .i_dut_done            (dut_done),
    .i_dut_cipher_text     (dut_cipher_text),
    .i_dut_completed_round (dut_completed_round),
    .o_busy                (busy),
    .o_finished            (finished),
    .o_pass                (pass),
    .o_error_count         (error_count),
    .o_first_fail_idx      (first_fail_idx),
    .o_timeout_err         (timeout_err),
    .o_round_err           (round_err)
  );

  function automatic int find_vec(input logic [DW-1:0] p);
    for (int j = 0; j < NV; j++) begin
      if (pt_tab[j] == p) return j;
    end
    return 0;
  endfunction

  // AES core stand-in: LAT cycles after start it returns the table ciphertext, stepping rounds.
  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      dut_done[l] = 1'b0;
      if (rst) begin
        m_act[l] = 1'b0;
        dut_completed_round[l*RN +: RN] = '0;
      end else if (!m_act[l]) begin
        if (dut_start[l]) begin
          m_act[l] = 1'b1;
          m_cnt[l] = 0;
          m_vec[l] = find_vec(dut_plain_text[l*DW +: DW]);
        end
      end else if (!dut_start[l]) begin
        m_act[l] = 1'b0;
        dut_completed_round[l*RN +: RN] = '0;
      end else begin
        m_cnt[l] = m_cnt[l] + 1;
        dut_completed_round[l*RN +: RN] = (m_cnt[l] <= RN) ? (RN'(1) << (m_cnt[l] - 1)) : RN'(0);
        if (round_bad && (m_cnt[l] == 2)) dut_completed_round[l*RN +: RN] = RN'(4);
        if ((m_cnt[l] == LAT) && !hang_mask[m_vec[l]]) begin
          dut_done[l] = 1'b1;
          dut_cipher_text[l*DW +: DW] = ct_tab[m_vec[l]] ^ (corrupt_mask[m_vec[l]] ? 128'h1 : 128'h0);
          m_act[l] = 1'b0;
          dut_completed_round[l*RN +: RN] = '0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [1:0] sel, input int addr, input logic [DW-1:0] data);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_addr = VW'(addr); ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic pulse_run();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_finished(input string tag);
    int k;
    k = 0;
    while (!finished && (k < 600)) begin
      @(negedge clk);
      k++;
    end
    check(tag, finished, 1'b1);
  endtask

  task automatic run_and_check(input string tag, input logic exp_pass, input int exp_err,
                               input int exp_ffi, input logic exp_to, input logic exp_re);
    pulse_run();
    check({tag, "_finished_cleared"}, finished, 1'b0);
    wait_finished({tag, "_finished"});
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_error_count"}, error_count, 128'(exp_err));
    check({tag, "_first_fail"}, first_fail_idx, 128'(exp_ffi));
    check({tag, "_timeout_err"}, timeout_err, exp_to);
    check({tag, "_round_err"}, round_err, exp_re);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_sel = 2'd0; ld_addr = '0; ld_data = '0; run = 1'b0;
    pt_tab[0]  = 128'h00112233445566778899aabbccddeeff;
    key_tab[0] = 128'h000102030405060708090a0b0c0d0e0f;
    ct_tab[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    for (int j = 1; j < NV; j++) begin
      pt_tab[j]  = 128'h11110000000000000000000000000000 | 128'(j);
      key_tab[j] = 128'hc0de0000000000000000000000000000 | 128'(j * 3);
      ct_tab[j]  = 128'hfeedface000000000000000000000000 | 128'(j * 7);
    end

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_finished", finished, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_error_count", error_count, 128'h0);
    check("rst_first_fail", first_fail_idx, 128'hf);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_round_err", round_err, 1'b0);
    check("rst_dut_start", dut_start, 128'h0);
    check("rst_plain_text", dut_plain_text, 128'h0);
    rst = 1'b0;

    for (int j = 0; j < NV; j++) begin
      write_word(2'd0, j, pt_tab[j]);
      write_word(2'd1, j, key_tab[j]);
      write_word(2'd2, j, ct_tab[j]);
    end
    write_word(2'd3, 0, 128'hdead);

    run_and_check("clean", 1'b1, 0, 15, 1'b0, 1'b0);

    corrupt_mask = 10'b0010001000;
    run_and_check("corrupt_3_7", 1'b0, 2, 3, 1'b0, 1'b0);
    corrupt_mask = '0;

    hang_mask = 10'b0000000100;
    run_and_check("hang_2", 1'b0, 1, 2, 1'b1, 1'b0);
    hang_mask = '0;

    round_bad = 1'b1;
    run_and_check("round_skip", 1'b0, 0, 15, 1'b0, 1'b1);
    round_bad = 1'b0;
    run_and_check("round_legal", 1'b1, 0, 15, 1'b0, 1'b0);

    pulse_run();
    repeat (5) @(posedge clk);
    #1;
    check("midrun_start_active", dut_start, 128'hf);
    check("midrun_lane0_plain", dut_plain_text[DW-1:0], pt_tab[0]);
    check("midrun_lane0_key", dut_cipher_key[DW-1:0], key_tab[0]);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_dut_start", dut_start, 128'h0);
    check("abort_first_fail", first_fail_idx, 128'hf);
    @(negedge clk);
    rst = 1'b0;
    run_and_check("after_abort", 1'b1, 0, 15, 1'b0, 1'b0);

    pulse_run();
    repeat (3) @(negedge clk);
    run = 1'b1; ld_en = 1'b1; ld_sel = 2'd2; ld_addr = VW'(9); ld_data = 128'hbad;
    @(negedge clk);
    run = 1'b0; ld_en = 1'b0;
    check("disturb_busy", busy, 1'b1);
    wait_finished("disturb_finished");
    check("disturb_pass", pass, 1'b1);
    check("disturb_error_count", error_count, 128'h0);
    run_and_check("ram_unchanged", 1'b1, 0, 15, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
